// File: rtl/idx_mask_builder.sv
// -----------------------------------------------------------------------------
// idx_mask_builder
//
// Streaming index-to-mask expander. Each accepted index beat is decoded to a
// one-hot (bit idx) or thermometer (bits idx..0) pattern. The patterns are
// OR-accumulated across a frame. One registered result is then presented per
// frame: the mask, a saturating beat count, and a duplicate flag.
//
// State table
//    state    | meaning
//    ---------+--------------------------------------------------------------
//    ST_ACCUM | accepting index beats, accumulating mask/count/dup
//    ST_HOLD  | frame result presented on out_*, waiting for out_ready
//
// Ports
//    clk        rising-edge clock
//    rst        asynchronous active-high reset
//    in_valid   index beat valid
//    in_ready   beat can be accepted (state only, never from in_valid)
//    in_idx     bit position to set
//    in_therm   1 = thermometer decode (idx..0), 0 = one-hot (idx only)
//    in_last    final beat of the frame
//    out_valid  frame result valid
//    out_ready  consumer accepts the result
//    out_mask   OR of all decoded beats in the frame
//    out_cnt    beats in the frame, saturating at 2**CNT_W-1
//    out_dup    some beat hit a bit already set by an earlier beat
// -----------------------------------------------------------------------------
module idx_mask_builder #(
   parameter int IDX_W  = 5,
   parameter int MASK_W = 32,
   parameter int CNT_W  = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IDX_W-1:0]  in_idx,
   input  logic              in_therm,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [MASK_W-1:0] out_mask,
   output logic [CNT_W-1:0]  out_cnt,
   output logic              out_dup
);

   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_HOLD  = 1'b1
   } state_t;

   state_t state_q, state_d;

   logic [MASK_W-1:0] acc_mask_q, acc_mask_d;
   logic [CNT_W-1:0]  acc_cnt_q,  acc_cnt_d;
   logic              acc_dup_q,  acc_dup_d;

   logic              out_valid_q, out_valid_d;
   logic [MASK_W-1:0] out_mask_q,  out_mask_d;
   logic [CNT_W-1:0]  out_cnt_q,   out_cnt_d;
   logic              out_dup_q,   out_dup_d;

   logic              accept;
   logic              hit;
   logic [MASK_W:0]   one_wide;
   logic [MASK_W:0]   therm_wide;
   logic [MASK_W-1:0] dec;
   logic [CNT_W-1:0]  cnt_inc;

   assign accept = in_valid && (state_q == ST_ACCUM);

   // Decode is done one bit wider than the mask so (2<<idx)-1 at the top
   // index wraps cleanly to all ones in the low MASK_W bits.
   always_comb begin
      one_wide   = {{MASK_W{1'b0}}, 1'b1} << in_idx;
      therm_wide = (one_wide << 1) - {{MASK_W{1'b0}}, 1'b1};
      dec        = in_therm ? therm_wide[MASK_W-1:0] : one_wide[MASK_W-1:0];
   end

   // Dup looks only at bits left by earlier beats, so a beat never flags
   // itself regardless of decode mode.
   assign hit     = acc_mask_q[in_idx];
   assign cnt_inc = (acc_cnt_q == {CNT_W{1'b1}}) ? acc_cnt_q
                                                 : acc_cnt_q + CNT_W'(1);

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_ACCUM;
         acc_mask_q  <= '0;
         acc_cnt_q   <= '0;
         acc_dup_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_mask_q  <= '0;
         out_cnt_q   <= '0;
         out_dup_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_mask_q  <= acc_mask_d;
         acc_cnt_q   <= acc_cnt_d;
         acc_dup_q   <= acc_dup_d;
         out_valid_q <= out_valid_d;
         out_mask_q  <= out_mask_d;
         out_cnt_q   <= out_cnt_d;
         out_dup_q   <= out_dup_d;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_ACCUM: if (accept && in_last) state_d = ST_HOLD;
         ST_HOLD:  if (out_ready)         state_d = ST_ACCUM;
         default:                         state_d = ST_ACCUM;
      endcase
   end

   // Accumulator and result registers
   always_comb begin
      acc_mask_d  = acc_mask_q;
      acc_cnt_d   = acc_cnt_q;
      acc_dup_d   = acc_dup_q;
      out_valid_d = out_valid_q;
      out_mask_d  = out_mask_q;
      out_cnt_d   = out_cnt_q;
      out_dup_d   = out_dup_q;

      if (accept) begin
         if (in_last) begin
            out_mask_d  = acc_mask_q | dec;
            out_cnt_d   = cnt_inc;
            out_dup_d   = acc_dup_q | hit;
            out_valid_d = 1'b1;
            acc_mask_d  = '0;
            acc_cnt_d   = '0;
            acc_dup_d   = 1'b0;
         end else begin
            acc_mask_d  = acc_mask_q | dec;
            acc_cnt_d   = cnt_inc;
            acc_dup_d   = acc_dup_q | hit;
         end
      end

      // out_* data keep their value after the handshake; only valid drops.
      if ((state_q == ST_HOLD) && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // ---------------------------------------------------------------------
   // Output logic (registered values and state only)
   // ---------------------------------------------------------------------
   always_comb begin
      in_ready  = (state_q == ST_ACCUM);
      out_valid = out_valid_q;
      out_mask  = out_mask_q;
      out_cnt   = out_cnt_q;
      out_dup   = out_dup_q;
   end

endmodule

// File: tb/tb_idx_mask_builder.sv
module tb_idx_mask_builder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_idx;
   logic        in_therm;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_mask;
   logic [5:0]  out_cnt;
   logic        out_dup;

   int checks   = 0;
   int failures = 0;

   idx_mask_builder #(.IDX_W(5), .MASK_W(32), .CNT_W(6)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_idx    (in_idx),
      .in_therm  (in_therm),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_mask  (out_mask),
      .out_cnt   (out_cnt),
      .out_dup   (out_dup)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]      n;
      logic [3:0][4:0] idx;
      logic [3:0]      therm;
      logic [31:0]     mask;
      logic [5:0]      cnt;
      logic            dup;
   } vec_t;

   vec_t vecs[10];

   function automatic vec_t mk(input int n, input int i0, input int i1,
                               input int i2, input int i3, input logic [3:0] th,
                               input logic [31:0] m, input int c, input logic d);
      vec_t v;
      v.n      = 3'(n);
      v.idx[0] = 5'(i0);
      v.idx[1] = 5'(i1);
      v.idx[2] = 5'(i2);
      v.idx[3] = 5'(i3);
      v.therm  = th;
      v.mask   = m;
      v.cnt    = 6'(c);
      v.dup    = d;
      return v;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
      end
   endtask

   // Present a beat at the falling edge, wait (bounded) for in_ready, and
   // return 1 time unit after the edge that accepted it.
   task automatic send_beat(input logic [4:0] idx, input logic th, input logic last);
      int n;
      @(negedge clk);
      in_valid = 1'b1;
      in_idx   = idx;
      in_therm = th;
      in_last  = last;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
   endtask

   // Called right after the last beat's accepting edge.
   task automatic collect(input string nm, input logic [31:0] m,
                          input logic [5:0] c, input logic d);
      check({nm, "_valid"}, 32'(out_valid), 32'd1);
      check({nm, "_in_ready"}, 32'(in_ready), 32'd0);
      check({nm, "_mask"}, out_mask, m);
      check({nm, "_cnt"}, 32'(out_cnt), 32'(c));
      check({nm, "_dup"}, 32'(out_dup), 32'(d));
      @(negedge clk);
      in_valid  = 1'b0;
      in_idx    = 'x;
      in_therm  = 'x;
      in_last   = 'x;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check({nm, "_valid_drop"}, 32'(out_valid), 32'd0);
      check({nm, "_ready_back"}, 32'(in_ready), 32'd1);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_idx    = '0;
      in_therm  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b0;

      vecs[0] = mk(1,  5,  0,  0,  0, 4'b0000, 32'h0000_0020, 1, 1'b0);
      vecs[1] = mk(1, 31,  0,  0,  0, 4'b0001, 32'hFFFF_FFFF, 1, 1'b0);
      vecs[2] = mk(1,  0,  0,  0,  0, 4'b0001, 32'h0000_0001, 1, 1'b0);
      vecs[3] = mk(3,  3,  7,  3,  0, 4'b0000, 32'h0000_0088, 3, 1'b1);
      vecs[4] = mk(2,  4,  2,  0,  0, 4'b0011, 32'h0000_001F, 2, 1'b1);
      vecs[5] = mk(2,  2,  1,  0,  0, 4'b0001, 32'h0000_0007, 2, 1'b1);
      vecs[6] = mk(2,  1,  3,  0,  0, 4'b0010, 32'h0000_000F, 2, 1'b0);
      vecs[7] = mk(2, 31,  0,  0,  0, 4'b0000, 32'h8000_0001, 2, 1'b0);
      vecs[8] = mk(4,  0,  8, 16, 24, 4'b0000, 32'h0101_0101, 4, 1'b0);
      vecs[9] = mk(3,  5,  5,  5,  0, 4'b0111, 32'h0000_003F, 3, 1'b1);

      #2;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_mask", out_mask, 32'd0);
      check("rst_out_cnt", 32'(out_cnt), 32'd0);
      check("rst_out_dup", 32'(out_dup), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Table-driven frames
      for (int v = 0; v < 10; v++) begin
         for (int b = 0; b < int'(vecs[v].n); b++) begin
            send_beat(vecs[v].idx[b], vecs[v].therm[b], (b == int'(vecs[v].n) - 1));
         end
         collect($sformatf("vec%0d", v), vecs[v].mask, vecs[v].cnt, vecs[v].dup);
      end

      // Backpressure: hold the result while a beat waits on the input.
      send_beat(5'd5, 1'b0, 1'b1);
      check("bp_first_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
      in_valid = 1'b1;
      in_idx   = 5'd9;
      in_therm = 1'b0;
      in_last  = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("bp_hold%0d_valid", k), 32'(out_valid), 32'd1);
         check($sformatf("bp_hold%0d_mask", k), out_mask, 32'h0000_0020);
         check($sformatf("bp_hold%0d_cnt", k), 32'(out_cnt), 32'd1);
         check($sformatf("bp_hold%0d_in_ready", k), 32'(in_ready), 32'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release_valid", 32'(out_valid), 32'd0);
      check("bp_release_in_ready", 32'(in_ready), 32'd1);
      check("bp_release_mask_kept", out_mask, 32'h0000_0020);
      @(negedge clk);
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      collect("bp_second", 32'h0000_0200, 6'd1, 1'b0);

      // Reset in the middle of a frame.
      send_beat(5'd1, 1'b0, 1'b0);
      send_beat(5'd2, 1'b0, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("rstmid_out_valid", 32'(out_valid), 32'd0);
      check("rstmid_in_ready", 32'(in_ready), 32'd1);
      check("rstmid_out_mask", out_mask, 32'd0);
      check("rstmid_out_cnt", 32'(out_cnt), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      send_beat(5'd4, 1'b0, 1'b1);
      collect("rstmid_after", 32'h0000_0010, 6'd1, 1'b0);

      // Reset while a result is held.
      send_beat(5'd6, 1'b1, 1'b1);
      check("rsthold_pre_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("rsthold_out_valid", 32'(out_valid), 32'd0);
      check("rsthold_in_ready", 32'(in_ready), 32'd1);
      check("rsthold_out_mask", out_mask, 32'd0);
      check("rsthold_out_dup", 32'(out_dup), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // 32 distinct one-hot beats: full mask, no duplicate.
      for (int i = 0; i < 32; i++) send_beat(5'(i), 1'b0, (i == 31));
      collect("full32", 32'hFFFF_FFFF, 6'd32, 1'b0);

      // 70 beats: count saturates at 63, wrap-around indices flag dup.
      for (int i = 0; i < 70; i++) send_beat(5'(i % 32), 1'b0, (i == 69));
      collect("sat70", 32'hFFFF_FFFF, 6'd63, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
